data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the MEM-stage interface.
- The memory stage drives the address from ALUOutM and the store data (writeData, optionally +1), plus the write enable, and expects ReadDataM back.
- This block range-checks and word-aligns each request and drives a synchronous backing RAM with fixed read latency.
- It stalls the pipeline for the duration of every load and returns registered read data.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the data region.
- DEPTH_WORDS, 1024, number of 32-bit words in the backing RAM (power of two).
- READ_LATENCY, 2, RAM cycles from address presented to ramReadData valid (legal range 1..4).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memRead  input  1  load request from the MEM stage (MemToReg of the instruction in MEM).
- writeEnable  input  1  store request from the MEM stage.
- address  input  32  byte address (ALUOutM).
- writeData  input  32  store data, already +1-adjusted by the MEM stage.
- readData  output  32  load result to the MEM stage (ReadDataM).
- stall  output  1  holds IF/ID/EX/MEM and the MEM/WB register while high.
- addrError  output  1  one-cycle pulse for an out-of-range or conflicting access.
- misaligned  output  1  one-cycle pulse when address[1:0] != 0.
- ramAddr  output  $clog2(DEPTH_WORDS)  word address to the RAM.
- ramWriteEnable  output  1  RAM write strobe.
- ramWriteData  output  32  RAM write data.
- ramReadData  input  32  RAM read data, valid READ_LATENCY cycles after ramAddr.

Behaviour:
- Clock and reset: single clock domain, rising edge of clock. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, latency counter = 0.
  - readData = 0, stall = 0, addrError = 0, misaligned = 0.
  - ramWriteEnable = 0, latched ramAddr = 0.
- Address decode:
  - inRange = (address >= BASE_ADDR) && (address - BASE_ADDR < DEPTH_WORDS*4), using a 33-bit subtraction so there is no wrap-around.
  - Word index = (address - BASE_ADDR)[ADDR_W+1:2]. The low two bits are dropped (truncated, not rounded).
- States: IDLE, WAIT, RESP.
- IDLE:
  - ramAddr = word index, combinational.
  - writeEnable && !memRead && inRange: ramWriteEnable = 1 and ramWriteData = writeData in the same cycle. No stall. Stay in IDLE.
  - memRead && !writeEnable && inRange: stall = 1 (combinational). Latch the word index, clear the counter, go to WAIT.
  - Out-of-range request: no RAM access and no stall. addrError pulses in the next cycle. readData is loaded with 0 at the edge, so the load completes with 0.
  - memRead && writeEnable together: illegal. The store is performed (if in range), no load is issued, and addrError pulses.
- WAIT:
  - stall = 1; ramAddr = latched index; ramWriteEnable = 0. All inputs are ignored.
  - The counter increments each cycle.
  - When counter == READ_LATENCY-1: readData <= ramReadData at the edge, go to RESP.
- RESP:
  - stall = 0; readData holds its value; inputs are ignored because this is the same instruction still in MEM. Go to IDLE.
- Load timing: a load stalls for exactly READ_LATENCY+1 cycles. Data is visible on readData from the RESP cycle onward.
- readData holds its last value until the next load or out-of-range load overwrites it. Stores never change it.
- misaligned: a registered pulse for any accepted request with address[1:0] != 0. The access still proceeds to the truncated word.
- Reset asserted mid-WAIT: return immediately to IDLE. stall drops asynchronously. The pending load is discarded and no RAM write occurs.

Decomposition:
- data_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the localparam ADDR_W = $clog2(DEPTH_WORDS) helper;
  - the maximum-latency constant 4, used by an elaboration-time assertion on READ_LATENCY.
- No sub-module is needed: the FSM, counter and range check form one block. The bench provides the RAM model with configurable latency.

Test Plan:
- Reset, then a store: writeEnable=1, address=0x10, writeData=0xCAFE0001 -> same cycle ramWriteEnable=1, ramAddr=4, ramWriteData=0xCAFE0001; stall stays 0.
- Load with READ_LATENCY=2 from address 0x10 holding 0xCAFE0001 -> stall high for cycles 0,1,2 and low in cycle 3; readData=0xCAFE0001 from cycle 3; state returns to IDLE in cycle 4.
- Load at BASE_ADDR+DEPTH_WORDS*4 (one past end) -> no stall, addrError pulses one cycle, readData=0; store to 0xFFFF_FFFC -> no RAM write, addrError pulses.
- Load at 0x13 -> misaligned pulse, ramAddr=4, returns word 4 data with normal stall length.
- memRead=1 and writeEnable=1 at 0x20 with data 0x5 -> RAM write of 0x5 to word 8, no stall, addrError pulse, readData unchanged.
- Reset asserted in cycle 1 of a load, RAM model loaded with 0x1234 -> stall falls immediately, readData=0, no RESP cycle; the next load of 0x1234 completes normally.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int MAX_READ_LATENCY = 4;

    function automatic int addr_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/data_mem_responder.sv
// Range-checks MEM-stage requests, drives a fixed-latency RAM, and stalls
// the pipeline for the duration of each load.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            memRead,
    input  logic                            writeEnable,
    input  logic [31:0]                     address,
    input  logic [31:0]                     writeData,
    output logic [31:0]                     readData,
    output logic                            stall,
    output logic                            addrError,
    output logic                            misaligned,
    output logic [$clog2(DEPTH_WORDS)-1:0]  ramAddr,
    output logic                            ramWriteEnable,
    output logic [31:0]                     ramWriteData,
    input  logic [31:0]                     ramReadData
);

    localparam int          ADDR_W   = addr_width(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS * 4);
    localparam logic [2:0]  LAST_CNT = 3'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("data_mem_responder: READ_LATENCY must be 1..4");
    end

    state_t              state, state_nxt;
    logic [2:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [32:0]         off;
    logic                in_range;
    logic [ADDR_W-1:0]   word_idx;
    logic                is_load;
    logic                conflict;

    // 33-bit offset so addresses below BASE_ADDR show up as a borrow, not a wrap
    assign off      = {1'b0, address} - {1'b0, BASE_ADDR};
    assign in_range = !off[32] && (off < SPAN);
    assign word_idx = off[ADDR_W+1:2];
    assign is_load  = memRead && !writeEnable;
    assign conflict = memRead && writeEnable;

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        ramAddr        = addr_q;
        ramWriteEnable = 1'b0;
        ramWriteData   = writeData;
        case (state)
            IDLE: begin
                ramAddr        = word_idx;
                ramWriteEnable = writeEnable && in_range;
                if (is_load && in_range) begin
                    stall     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == LAST_CNT) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset must release the pipeline and suppress RAM writes at once
        if (reset) begin
            stall          = 1'b0;
            ramWriteEnable = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            readData   <= '0;
            addrError  <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            addrError  <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (memRead || writeEnable) begin
                        if (!in_range) begin
                            addrError <= 1'b1;
                            if (is_load) readData <= '0;
                        end else begin
                            misaligned <= (address[1:0] != 2'b00);
                            if (conflict) addrError <= 1'b1;
                        end
                    end
                    if (is_load && in_range) begin
                        addr_q <= word_idx;
                        cnt    <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_CNT) readData <= ramReadData;
                end
                default: ;
            endcase
        end
    end

endmodule
